lsu_mem_initiator: RTL
======================

Name: lsu_mem_initiator

Overview:
- Load/store unit between the CPU execute stage and the byte-addressed data memory.
- Accepts load and store requests over a valid/ready handshake.
- Always drives the memory in word mode (width 2'b00) on word-aligned addresses. Does byte/half extraction with sign or zero extension itself.
- Sub-word stores are done as read-modify-write, because the memory write path overwrites all four bytes of the addressed word.
- Big-endian lanes: byte offset 0 is bits 31:24, offset 3 is bits 7:0.

Parameters:
- MEM_SIZE, 131072: memory size in bytes. Accesses with addr+3 >= MEM_SIZE are rejected.
- USABLE_MEM_START, 'h10000: lowest legal data address. Accesses below it are rejected.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 word, 01 half, 10 byte, 11 treated as word
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified for sub-word stores
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or out-of-range access
- mem_addr  out  32  word-aligned address to memory
- mem_wdata  out  32  word to write
- mem_wen  out  1  memory write enable
- mem_width  out  2  memory access width, constant 2'b00
- mem_rdata  in  32  combinational memory read word

Behaviour:
- Reset outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_wen=0, mem_addr=0, mem_wdata=0. FSM goes to IDLE. An in-flight access is abandoned with no write issued.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- req_ready is 1 only in IDLE. A request is accepted when req_valid & req_ready. All req_* fields are registered on acceptance.
- Checks at accept:
  - Misaligned: word with addr[1:0]!=0, or half with addr[0]!=0.
  - Out of range: addr < USABLE_MEM_START, or addr+3 >= MEM_SIZE.
  - Any failure goes straight to RESP with resp_err=1 and no memory cycle.
- Transitions from IDLE:
  - load -> LOAD
  - word store -> STORE
  - half/byte store -> RMW_RD
- mem_addr = {addr[31:2],2'b00} in every non-IDLE state.
- LOAD: one cycle. mem_rdata is captured, the lane is extracted and extended into resp_rdata. -> RESP.
  - Byte lane select: offset k uses bits [31-8k -: 8].
  - Half lane select: offset 0 uses [31:16], offset 2 uses [15:0].
- STORE: mem_wen=1 for exactly one cycle with mem_wdata=req_wdata. -> RESP.
- RMW_RD: capture mem_rdata. -> RMW_WR.
- RMW_WR: mem_wen=1 for one cycle. mem_wdata is the captured word with only the target lane(s) replaced by req_wdata[7:0] or [15:0]. -> RESP.
- RESP: resp_valid=1, outputs held stable until resp_ready. On resp_valid&resp_ready -> IDLE.
  - The next request cannot be accepted in that same cycle (no bypass).
- Latency, accept to resp_valid:
  - load and word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- mem_wen is never high outside STORE/RMW_WR.
- Reset asserted during RMW_RD or RMW_WR must leave memory unchanged.

Optional Feature:
- LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses produce resp_err=1 with no memory cycle.
- Undefined: low address bits of a misaligned access are forced aligned (word -> addr[1:0]=0, half -> addr[0]=0) and the access proceeds normally with resp_err=0. Range errors still report.

Decomposition:
- lsu_pkg holds:
  - typedef enum lsu_size_t {SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10}
  - typedef enum lsu_state_t for the FSM states
  - constant MEM_WIDTH_WORD=2'b00
- One combinational sub-module, lsu_lane: byte/half extract and extend, plus merge for RMW.

Test Plan:
- Memory word at 'h10000 = 32'h80FF_1234. Load byte signed at 'h10000 -> resp_rdata=32'hFFFF_FF80 two cycles after accept, resp_err=0.
- Same word, load half unsigned at 'h10002 -> resp_rdata=32'h0000_1234. Load half signed at 'h10000 -> resp_rdata=32'hFFFF_80FF.
- Store byte 8'hAB at 'h10001 over word 32'h1122_3344 -> single mem_wen pulse with mem_wdata=32'h11AB_3344; later word load returns 32'h11AB_3344.
- Load word at 'h0000_FFFC -> resp_err=1 after 1 cycle, mem_wen never asserted. Load word at 'h1FFFD -> resp_err=1.
- Load word at 'h10002: with LSU_MISALIGN_TRAP_EN -> resp_err=1; without it -> data of 'h10000, resp_err=0.
- Hold resp_ready=0 for 5 cycles -> resp_valid/resp_rdata stable and req_ready=0. Assert rst during RMW_WR -> memory word unchanged, req_ready=1 the cycle after reset.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } lsu_size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } lsu_state_t;

    localparam logic [1:0] MEM_WIDTH_WORD = 2'b00;

    // Encoding 2'b11 has no lane meaning and behaves as a full word.
    function automatic lsu_size_t decode_size(input logic [1:0] s);
        return (s == 2'b11) ? SZ_WORD : lsu_size_t'(s);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - big-endian lane extract/extend and read-modify-write merge
module lsu_lane
    import lsu_pkg::*;
(
    input  lsu_size_t   size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  byte_lsb;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Offset 0 is the most significant byte of the word.
    assign byte_lsb = {2'd3 - offset, 3'b000};

    always_comb begin
        load_data = word;
        merged    = word;
        byte_val  = word[byte_lsb +: 8];
        half_val  = offset[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_BYTE: begin
                load_data = is_unsigned ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
                merged[byte_lsb +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = is_unsigned ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
                if (offset[1]) merged[15:0]  = wdata;
                else           merged[31:16] = wdata;
            end
            default: begin
                load_data = word;
                merged    = word;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - load/store unit driving a word-wide data memory; LSU_MISALIGN_TRAP_EN traps misaligned accesses
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_SIZE         = 131072,
    parameter int unsigned USABLE_MEM_START = 'h10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic [1:0]  mem_width,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state;
    lsu_size_t   in_size;
    lsu_size_t   r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;
    logic [15:0] r_wdata;
    logic        wen_q;
    logic [1:0]  eff_off;
    logic [32:0] addr_end;
    logic        out_of_range;
    logic        misaligned;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign in_size      = decode_size(req_size);
    assign addr_end     = {1'b0, req_addr} + 33'd3;
    assign out_of_range = (req_addr < USABLE_MEM_START) || (addr_end >= 33'(MEM_SIZE));

    always_comb begin
        eff_off = req_addr[1:0];
        case (in_size)
            SZ_WORD: eff_off = 2'b00;
            SZ_HALF: eff_off = {req_addr[1], 1'b0};
            default: eff_off = req_addr[1:0];
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((in_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                        ((in_size == SZ_HALF) && req_addr[0]);
`else
    assign misaligned = 1'b0;
`endif

    lsu_lane u_lane (
        .size        (r_size),
        .offset      (r_off),
        .is_unsigned (r_unsigned),
        .word        (mem_rdata),
        .wdata       (r_wdata),
        .load_data   (load_data),
        .merged      (merged)
    );

    assign mem_width = MEM_WIDTH_WORD;
    // Gate the write strobe with reset so a reset landing on a write cycle cannot commit it.
    assign mem_wen   = wen_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            wen_q      <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            r_size     <= SZ_WORD;
            r_unsigned <= 1'b0;
            r_off      <= 2'b00;
            r_wdata    <= 16'h0;
        end else begin
            wen_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        r_size     <= in_size;
                        r_unsigned <= req_unsigned;
                        r_off      <= eff_off;
                        r_wdata    <= req_wdata[15:0];
                        mem_addr   <= {req_addr[31:2], 2'b00};
                        if (out_of_range || misaligned) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (!req_we) begin
                            state <= ST_LOAD;
                        end else if (in_size == SZ_WORD) begin
                            state     <= ST_STORE;
                            wen_q     <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state <= ST_RMW_RD;
                        end
                    end
                end
                ST_LOAD: begin
                    resp_rdata <= load_data;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RMW_RD: begin
                    mem_wdata <= merged;
                    wen_q     <= 1'b1;
                    state     <= ST_RMW_WR;
                end
                ST_STORE, ST_RMW_WR: begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
